// File: rtl/dma_loopback_pkg.sv
// Shared types and helpers for the DMA loopback engine.
package dma_loopback_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned line_bytes(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/dma_fifo.sv
// Show-ahead FIFO: head_c always presents the oldest entry; count/empty/full are registered.
module dma_fifo
  import dma_loopback_pkg::*;
#(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head_c  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_next = count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == (AW+1)'(DEPTH));
    end
  end

  // Storage is not reset; consumers gate the head with empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dma_loopback_ctrl.sv
// DMA loopback engine: copies size lines from rd_addr to wr_addr through a credit-limited buffer.
// Optional feature: define DMA_LOOPBACK_PERF_EN to add the 32-bit BUSY cycle counter output.
module dma_loopback_ctrl
  import dma_loopback_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned SIZE_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [SIZE_WIDTH-1:0] size,
  output logic                  done,
`ifdef DMA_LOOPBACK_PERF_EN
  output logic [31:0]           cycles,
`endif
  output logic                  rd_req_en,
  output logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic                  rd_req_full,
  input  logic                  rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0] rd_rsp_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_req_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_full,
  input  logic                  wr_rsp_valid
);

  localparam int unsigned LINE_BYTES = line_bytes(DATA_WIDTH);
  localparam int unsigned CW         = SIZE_WIDTH + 1;
  localparam int unsigned FCW        = $clog2(FIFO_DEPTH) + 1;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] rd_base;
  logic [ADDR_WIDTH-1:0] wr_base;
  logic [CW-1:0]         size_q;
  logic [CW-1:0]         rd_issued;
  logic [CW-1:0]         rd_received;
  logic [CW-1:0]         wr_issued;
  logic [CW-1:0]         wr_acked;
  logic [CW-1:0]         acked_next;
  logic [CW-1:0]         occupancy;
  logic                  busy;
  logic                  accept_go;
  logic                  credit_ok;
  logic                  rsp_push;
  logic                  ack_take;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [FCW-1:0]        fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;

  assign busy      = (state == BUSY);
  assign accept_go = go && !busy;
  assign rsp_push  = busy && rd_rsp_valid;
  assign ack_take  = busy && wr_rsp_valid;

  // Lines owned by the buffer: already stored plus still in flight from the read port.
  assign occupancy = CW'(fifo_count) + (rd_issued - rd_received);
  assign credit_ok = !fifo_full && (occupancy < CW'(FIFO_DEPTH));

  assign rd_req_en   = busy && (rd_issued < size_q) && !rd_req_full && credit_ok;
  assign wr_en       = busy && !fifo_empty && !wr_full;
  assign rd_req_addr = rd_base + ADDR_WIDTH'(rd_issued) * ADDR_WIDTH'(LINE_BYTES);
  assign wr_req_addr = wr_base + ADDR_WIDTH'(wr_issued) * ADDR_WIDTH'(LINE_BYTES);
  assign wr_data     = fifo_empty ? '0 : fifo_head;
  assign acked_next  = wr_acked + CW'(ack_take);

  dma_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .push_data (rd_rsp_data),
    .pop       (wr_en),
    .head_c    (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state; completion is taken on the edge that samples the final ack.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (go) state_next = (size == '0) ? DONE : BUSY;
      end
      BUSY: begin
        if (acked_next == size_q) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_base     <= '0;
      wr_base     <= '0;
      size_q      <= '0;
      rd_issued   <= '0;
      rd_received <= '0;
      wr_issued   <= '0;
      wr_acked    <= '0;
    end else if (accept_go) begin
      rd_base     <= rd_addr;
      wr_base     <= wr_addr;
      size_q      <= CW'(size);
      rd_issued   <= '0;
      rd_received <= '0;
      wr_issued   <= '0;
      wr_acked    <= '0;
    end else begin
      if (rd_req_en) rd_issued   <= rd_issued + CW'(1);
      if (rsp_push)  rd_received <= rd_received + CW'(1);
      if (wr_en)     wr_issued   <= wr_issued + CW'(1);
      wr_acked <= acked_next;
    end
  end

`ifdef DMA_LOOPBACK_PERF_EN
  // BUSY cycle counter: saturating, held in DONE, cleared by an accepted go.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles <= '0;
    end else if (accept_go) begin
      cycles <= '0;
    end else if (busy && (cycles != '1)) begin
      cycles <= cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dma_loopback_ctrl.sv
// Directed bench for dma_loopback_ctrl with a latency-modelled read port and write-ack port.
module tb_dma_loopback_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         go;
  logic [63:0]  rd_addr;
  logic [63:0]  wr_addr;
  logic [15:0]  size;
  logic         done;
  logic         rd_req_en;
  logic [63:0]  rd_req_addr;
  logic         rd_req_full;
  logic         rd_rsp_valid;
  logic [511:0] rd_rsp_data;
  logic         wr_en;
  logic [63:0]  wr_req_addr;
  logic [511:0] wr_data;
  logic         wr_full;
  logic         wr_rsp_valid;
`ifdef DMA_LOOPBACK_PERF_EN
  logic [31:0]  cycles;
`endif

  dma_loopback_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .go           (go),
    .rd_addr      (rd_addr),
    .wr_addr      (wr_addr),
    .size         (size),
    .done         (done),
`ifdef DMA_LOOPBACK_PERF_EN
    .cycles       (cycles),
`endif
    .rd_req_en    (rd_req_en),
    .rd_req_addr  (rd_req_addr),
    .rd_req_full  (rd_req_full),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .wr_en        (wr_en),
    .wr_req_addr  (wr_req_addr),
    .wr_data      (wr_data),
    .wr_full      (wr_full),
    .wr_rsp_valid (wr_rsp_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } rreq_t;

  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  rreq_t        rq[$];
  int           aq[$];
  logic [63:0]  rd_log[$];
  logic [63:0]  wr_alog[$];
  logic [511:0] wr_dlog[$];
  int           rd_lat = 2;
  int           wr_lat = 2;
  bit           bp = 0;
  int           wr_hold = 0;
  int           inject = 0;
  int           acc_rd = 0;
  int           acc_wr = 0;
  int           max_inflight = 0;
  int           last_ack_cyc = -1;
  int           done_rise_cyc = -1;
  bit           prev_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] mem_data(input logic [63:0] a);
    return {8{a ^ 64'hA5A5_0F0F_3C3C_5A5A}};
  endfunction

  // Host memory model: drive port inputs at negedge, then record what the DUT issues this cycle.
  initial begin
    rd_req_full  = 1'b0;
    wr_full      = 1'b0;
    rd_rsp_valid = 1'b0;
    rd_rsp_data  = '0;
    wr_rsp_valid = 1'b0;
    forever begin
      @(negedge clk);
      rd_req_full  = bp && ($urandom_range(0, 3) == 0);
      wr_full      = bp && ($urandom_range(0, 3) == 0);
      if (wr_hold > 0) begin
        wr_full = 1'b1;
        wr_hold--;
      end
      rd_rsp_valid = 1'b0;
      wr_rsp_valid = 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = mem_data(rq[0].addr);
        rq.delete(0);
      end else if (inject > 0) begin
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = {16{32'hDEAD_BEEF}};
      end
      if (aq.size() > 0 && aq[0] <= cyc) begin
        wr_rsp_valid = 1'b1;
        last_ack_cyc = cyc;
        aq.delete(0);
      end else if (inject > 0) begin
        wr_rsp_valid = 1'b1;
      end
      if (inject > 0) inject--;
      #1;
      if (rd_req_en && !rd_req_full) begin
        rq.push_back('{rd_req_addr, cyc + rd_lat});
        rd_log.push_back(rd_req_addr);
        acc_rd++;
      end
      if (wr_en && !wr_full) begin
        wr_alog.push_back(wr_req_addr);
        wr_dlog.push_back(wr_data);
        aq.push_back(cyc + wr_lat);
        acc_wr++;
      end
      if (acc_rd - acc_wr > max_inflight) max_inflight = acc_rd - acc_wr;
      if (done && !prev_done) done_rise_cyc = cyc;
      prev_done = done;
    end
  end

  task automatic clear_logs();
    rd_log.delete();
    wr_alog.delete();
    wr_dlog.delete();
    acc_rd        = 0;
    acc_wr        = 0;
    max_inflight  = 0;
    last_ack_cyc  = -1;
    done_rise_cyc = -1;
  endtask

  // Pulse go for one edge; returns just after that edge (cycle N+1).
  task automatic start(input logic [63:0] ra, input logic [63:0] wa, input logic [15:0] sz);
    @(negedge clk);
    rd_addr = ra;
    wr_addr = wa;
    size    = sz;
    go      = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      n++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: done=%0b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (rd_req_en !== 1'b0) begin errors++; $display("FAIL reset_rd_req_en: got %0b want 0", rd_req_en); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %0b want 0", wr_en); end
    checks++; if (rd_req_addr !== 64'h0) begin errors++; $display("FAIL reset_rd_req_addr: got %h want 0", rd_req_addr); end
    checks++; if (wr_req_addr !== 64'h0) begin errors++; $display("FAIL reset_wr_req_addr: got %h want 0", wr_req_addr); end
    checks++; if (wr_data !== 512'h0) begin errors++; $display("FAIL reset_wr_data: got nonzero want 0"); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int n;
    clear_logs();
    rd_lat = 2; wr_lat = 2; bp = 1'b0;
    start(64'h1000, 64'h2000, 16'd1);
    wait_done(200, n);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rd_log.size() !== 1) begin errors++; $display("FAIL single_rd_count: got %0d want 1", rd_log.size()); end
    checks++; if (rd_log[0] !== 64'h1000) begin errors++; $display("FAIL single_rd_addr: got %h want 1000", rd_log[0]); end
    checks++; if (wr_alog.size() !== 1) begin errors++; $display("FAIL single_wr_count: got %0d want 1", wr_alog.size()); end
    checks++; if (wr_alog[0] !== 64'h2000) begin errors++; $display("FAIL single_wr_addr: got %h want 2000", wr_alog[0]); end
    checks++; if (wr_dlog[0] !== mem_data(64'h1000)) begin errors++; $display("FAIL single_wr_data: got %h want %h", wr_dlog[0][63:0], mem_data(64'h1000) >> 448); end
    checks++; if (done_rise_cyc !== last_ack_cyc + 1) begin errors++; $display("FAIL single_done_latency: rose at %0d want %0d", done_rise_cyc, last_ack_cyc + 1); end
  endtask

  task automatic test_stream64();
    int n;
    int addr_err;
    int data_err;
    clear_logs();
    rd_lat = 20; wr_lat = 4; bp = 1'b1;
    start(64'h10000, 64'h80000, 16'd64);
    wait_done(3000, n);
    bp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    addr_err = 0;
    data_err = 0;
    for (int i = 0; i < 64; i++) begin
      if (rd_log[i] !== 64'h10000 + 64'(i) * 64'd64) addr_err++;
      if (wr_alog[i] !== 64'h80000 + 64'(i) * 64'd64) addr_err++;
      if (wr_dlog[i] !== mem_data(64'h10000 + 64'(i) * 64'd64)) data_err++;
    end
    checks++; if (rd_log.size() !== 64) begin errors++; $display("FAIL stream_rd_count: got %0d want 64", rd_log.size()); end
    checks++; if (wr_alog.size() !== 64) begin errors++; $display("FAIL stream_wr_count: got %0d want 64", wr_alog.size()); end
    checks++; if (addr_err !== 0) begin errors++; $display("FAIL stream_addr: %0d bad addresses, want 0", addr_err); end
    checks++; if (data_err !== 0) begin errors++; $display("FAIL stream_data: %0d bad lines, want 0", data_err); end
    checks++; if (max_inflight > 16) begin errors++; $display("FAIL stream_credit_bound: peak %0d want <=16", max_inflight); end
    checks++; if (max_inflight !== 16) begin errors++; $display("FAIL stream_credit_used: peak %0d want 16", max_inflight); end
  endtask

  task automatic test_zero_size();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_logs();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_pre_done: got %0b want 0", done); end
    start(64'h3000, 64'h5000, 16'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_n1: got %0b want 1", done); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (rd_log.size() !== 0) begin errors++; $display("FAIL zero_reads: got %0d want 0", rd_log.size()); end
    checks++; if (wr_alog.size() !== 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wr_alog.size()); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_hold: got %0b want 1", done); end
  endtask

  task automatic test_go_ignored();
    int n;
    int bad;
    clear_logs();
    rd_lat = 5; wr_lat = 3; bp = 1'b0;
    start(64'h4000, 64'h6000, 16'd8);
    repeat (3) @(posedge clk);
    #1;
    start(64'h9000, 64'hA000, 16'd4);
    wait_done(300, n);
    repeat (2) @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (wr_alog[i] !== 64'h6000 + 64'(i) * 64'd64) bad++;
      if (wr_dlog[i] !== mem_data(64'h4000 + 64'(i) * 64'd64)) bad++;
    end
    checks++; if (wr_alog.size() !== 8) begin errors++; $display("FAIL busy_go_count: got %0d want 8", wr_alog.size()); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL busy_go_lines: %0d bad fields want 0", bad); end
    clear_logs();
    start(64'h9000, 64'hA000, 16'd2);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL restart_done_clear: got %0b want 0", done); end
    wait_done(300, n);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wr_alog.size() !== 2) begin errors++; $display("FAIL restart_count: got %0d want 2", wr_alog.size()); end
    checks++; if (wr_alog[1] !== 64'hA040) begin errors++; $display("FAIL restart_addr: got %h want a040", wr_alog[1]); end
    checks++; if (wr_dlog[1] !== mem_data(64'h9040)) begin errors++; $display("FAIL restart_data: line 1 got %h", wr_dlog[1][63:0]); end
  endtask

  task automatic test_spurious();
    int n;
    clear_logs();
    rd_lat = 2; wr_lat = 2; bp = 1'b0;
    inject = 4;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL spurious_done_hold: got %0b want 1", done); end
    start(64'hC000, 64'hD000, 16'd2);
    wait_done(200, n);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wr_alog.size() !== 2) begin errors++; $display("FAIL spurious_count: got %0d want 2", wr_alog.size()); end
    checks++; if (wr_dlog[0] !== mem_data(64'hC000)) begin errors++; $display("FAIL spurious_data: line 0 got %h", wr_dlog[0][63:0]); end
    checks++; if (done_rise_cyc !== last_ack_cyc + 1) begin errors++; $display("FAIL spurious_done_latency: rose at %0d want %0d", done_rise_cyc, last_ack_cyc + 1); end
  endtask

  task automatic test_reset_mid();
    int n;
    int wc;
    int rc;
    clear_logs();
    rd_lat = 8; wr_lat = 3; bp = 1'b0;
    start(64'h20000, 64'h30000, 16'd32);
    n = 0;
    while (wr_alog.size() < 10 && n < 500) begin
      n++;
      @(posedge clk);
      #1;
    end
    checks++; if (wr_alog.size() < 10) begin errors++; $display("FAIL midrst_progress: got %0d writes want >=10", wr_alog.size()); end
    @(negedge clk);
    rst = 1'b1;
    #2;
    wc = wr_alog.size();
    rc = rd_log.size();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %0b want 0", done); end
    checks++; if (rd_req_en !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL midrst_en: rd=%0b wr=%0b want 0 0", rd_req_en, wr_en); end
    checks++; if (rd_req_addr !== 64'h0 || wr_req_addr !== 64'h0) begin errors++; $display("FAIL midrst_addr: rd=%h wr=%h want 0 0", rd_req_addr, wr_req_addr); end
    checks++; if (wr_data !== 512'h0) begin errors++; $display("FAIL midrst_wr_data: got nonzero want 0"); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (wr_alog.size() !== wc) begin errors++; $display("FAIL midrst_no_writes: got %0d want %0d", wr_alog.size(), wc); end
    checks++; if (rd_log.size() !== rc) begin errors++; $display("FAIL midrst_no_reads: got %0d want %0d", rd_log.size(), rc); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_idle_done: got %0b want 0", done); end
  endtask

`ifdef DMA_LOOPBACK_PERF_EN
  task automatic test_perf();
    int n;
    clear_logs();
    rd_lat = 2; wr_lat = 2; bp = 1'b0;
    start(64'h1000, 64'h2000, 16'd8);
    wr_hold = 5;
    wait_done(300, n);
    checks++; if (cycles !== 32'(n)) begin errors++; $display("FAIL perf_cycles: got %0d want %0d", cycles, n); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cycles !== 32'(n)) begin errors++; $display("FAIL perf_hold: got %0d want %0d", cycles, n); end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    go      = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    size    = '0;
    test_reset();
    test_single();
    test_stream64();
    test_zero_size();
    test_go_ignored();
    test_spurious();
    test_reset_mid();
`ifdef DMA_LOOPBACK_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_loopback_ctrl.md
# dma_loopback_ctrl

DMA engine that consumes the `go`, `rd_addr`, `wr_addr` and `size` registers produced by the MMIO register block and returns `done` to it. It streams `size` cache lines from host memory at `rd_addr` to host memory at `wr_addr` through an internal buffer. Issued reads are credit-limited so the buffer never overflows, even though read responses cannot be stalled. It sits between the MMIO register block and the platform DMA read/write ports.

## Interface
- `ADDR_WIDTH`, 64, width of byte addresses.
- `SIZE_WIDTH`, 16, width of the line count; max transfer is 2**SIZE_WIDTH-1 lines.
- `DATA_WIDTH`, 512, cache-line width in bits; `LINE_BYTES = DATA_WIDTH/8`.
- `FIFO_DEPTH`, 16, buffer depth in lines; must be a power of 2.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `go`  in  1  single-cycle start pulse.
- `rd_addr`, `wr_addr`  in  ADDR_WIDTH  start byte addresses, line aligned.
- `size`  in  SIZE_WIDTH  number of lines.
- `done`  out  1  transfer complete.
- `rd_req_en`  out  1  issue a read request this cycle.
- `rd_req_addr`  out  ADDR_WIDTH  read byte address.
- `rd_req_full`  in  1  read port cannot accept a request.
- `rd_rsp_valid`  in  1  read data valid; returned in request order; cannot be stalled.
- `rd_rsp_data`  in  DATA_WIDTH  read data.
- `wr_en`  out  1  issue a write this cycle.
- `wr_req_addr`  out  ADDR_WIDTH  write byte address.
- `wr_data`  out  DATA_WIDTH  write data.
- `wr_full`  in  1  write port cannot accept a request.
- `wr_rsp_valid`  in  1  one write completion acknowledged.

## Operation
- States:
  - IDLE: reset state.
  - BUSY: transfer in progress.
  - DONE: transfer complete; `done`=1.
- Starting a transfer:
  - `go` in IDLE or DONE latches `rd_addr`, `wr_addr` and `size`, clears `done`, clears all counters, and enters BUSY.
  - `go` while in BUSY is ignored.
  - `go` with `size`=0 goes directly to DONE.
- Read issue rule: `rd_req_en` = BUSY & `rd_issued`<`size` & !`rd_req_full` & credits>0.
  - `credits = FIFO_DEPTH - fifo_count - outstanding_reads`.
  - `rd_req_addr` = latched `rd_addr` + `rd_issued`*`LINE_BYTES`.
- Buffering: every `rd_rsp_valid` pushes `rd_rsp_data` into the FIFO.
- Write issue rule: `wr_en` = BUSY & FIFO not empty & !`wr_full`.
  - `wr_data` = FIFO head (show-ahead); the FIFO pops on `wr_en`.
  - `wr_req_addr` = latched `wr_addr` + `wr_issued`*`LINE_BYTES`.
- Completion: BUSY -> DONE when `wr_acked`==`size`.
- `done` holds until the next accepted `go`.
- Counter widths and wrap:
  - Line counters are SIZE_WIDTH+1 bits wide.
  - Address arithmetic wraps modulo 2**ADDR_WIDTH.
- Simultaneous events: a push and a pop in the same cycle leave `fifo_count` unchanged.
- Unexpected traffic: `rd_rsp_valid` or `wr_rsp_valid` arriving in IDLE or DONE is ignored.
- Reset mid-transfer: all state returns to IDLE. Responses still in flight afterwards are ignored.

## Timing
- Reset values:
  - `done`=0, `rd_req_en`=0, `wr_en`=0.
  - `rd_req_addr`=0, `wr_req_addr`=0, `wr_data`=0.
- Start latency:
  - `go` sampled at edge N.
  - First `rd_req_en` is possible in cycle N+1.
  - For `size`=0, `done`=1 from cycle N+1.
- Data path latency:
  - A response pushed at edge M can be written in cycle M+1 at the earliest.
  - Steady-state throughput is one line per cycle when no backpressure is applied.
- Handshake: `rd_req_full` and `wr_full` are sampled combinationally in the issue cycle. A request asserted while the port is full is not counted.
- Done latency: `done` rises in the cycle after the final `wr_rsp_valid`.

## Configuration
- `DMA_LOOPBACK_PERF_EN` defined:
  - Adds output `cycles` (32 bits, reset 0).
  - `cycles` clears on an accepted `go`, increments every BUSY cycle, saturates at all-ones, and holds in DONE.
- `DMA_LOOPBACK_PERF_EN` undefined: the `cycles` port and its counter do not exist.

## Structure
- Package `dma_loopback_pkg` holds:
  - state enum `state_t` {IDLE, BUSY, DONE};
  - function `line_bytes(DATA_WIDTH)`.
- Sub-module `dma_fifo`:
  - show-ahead FIFO parameterized by width and depth;
  - registered `count`, `empty` and `full` outputs;
  - async reset.
- All other logic lives in the top level: FSM, counters and issue logic.

## Test plan
- `size`=1, `rd_addr`=0x1000, `wr_addr`=0x2000, no backpressure, 2-cycle read latency -> one read at 0x1000, one write at 0x2000 with identical data; `done`=1 one cycle after the ack.
- `size`=64, random `rd_req_full`/`wr_full`, read latency 20 -> addresses increment by 0x40; data matches in order; `fifo_count` never exceeds 16; outstanding reads + `fifo_count` never exceed 16.
- `size`=0 -> `done`=1 in cycle N+1; `rd_req_en` and `wr_en` never assert.
- Second `go` mid-transfer with different addresses -> ignored; original transfer completes unchanged. A later `go` from DONE clears `done` and runs the new transfer.
- `rst` asserted after 10 of 32 lines with responses still arriving -> IDLE immediately; outputs at reset values; no writes issued afterwards.
- With `DMA_LOOPBACK_PERF_EN`, `size`=8, `wr_full` held high for 5 cycles -> `cycles` equals the measured BUSY duration and holds after `done`.
